// File: rtl/decode_queue.sv
// RV32I decode stage feeding an in-order DEPTH-entry queue with valid/ready on both sides.
// Optional macro DECODE_IMM_EN: when defined, the immediate is decoded and stored; otherwise o_imm is 0.
module decode_queue #(
  parameter int TAG_W = 4,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [31:0]      i_instr,
  input  logic [31:0]      i_next_pc,
  input  logic [TAG_W-1:0] i_tag,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [4:0]       o_rs1,
  output logic [4:0]       o_rs2,
  output logic [4:0]       o_rd,
  output logic [31:0]      o_instr,
  output logic [31:0]      o_next_pc,
  output logic [2:0]       o_instr_format,
  output logic [2:0]       o_alu_sel,
  output logic [2:0]       o_instr_type,
  output logic [31:0]      o_imm,
  output logic             o_illegal,
  output logic [TAG_W-1:0] o_tag,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [2:0] FMT_I = 3'd0, FMT_S = 3'd1, FMT_B = 3'd2,
                         FMT_U = 3'd3, FMT_J = 3'd4, FMT_R = 3'd5;
  localparam logic [2:0] ALU_ADDER = 3'd0, ALU_LOGICAL = 3'd1, ALU_SHIFTER = 3'd2,
                         ALU_BRANCH = 3'd3, ALU_MEMORY = 3'd4, ALU_BYPASS = 3'd5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111, OPC_AUIPC = 7'b0010111,
                         OPC_JAL    = 7'b1101111, OPC_JALR  = 7'b1100111,
                         OPC_BRANCH = 7'b1100011, OPC_LOAD  = 7'b0000011,
                         OPC_STORE  = 7'b0100011, OPC_OPIMM = 7'b0010011,
                         OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic [31:0]      instr;
    logic [31:0]      next_pc;
    logic [2:0]       fmt;
    logic [2:0]       alu;
    logic [2:0]       typ;
    logic             illegal;
    logic [TAG_W-1:0] tag;
`ifdef DECODE_IMM_EN
    logic [31:0]      imm;
`endif
  } entry_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [2:0] fmt_d;
  logic [2:0] alu_sel_d;
  logic [2:0] instr_type_d;
  logic       illegal_d;

  assign opcode = i_instr[6:0];
  assign funct3 = i_instr[14:12];
  assign funct7 = i_instr[31:25];

  always_comb begin
    case (opcode)
      OPC_OPIMM, OPC_JALR, OPC_LOAD: fmt_d = FMT_I;
      OPC_STORE:                     fmt_d = FMT_S;
      OPC_BRANCH:                    fmt_d = FMT_B;
      OPC_LUI, OPC_AUIPC:            fmt_d = FMT_U;
      OPC_JAL:                       fmt_d = FMT_J;
      default:                       fmt_d = FMT_R;
    endcase
  end

  // Illegal encodings only raise the flag; unit/op stay at BYPASS/OP0.
  always_comb begin
    alu_sel_d    = ALU_BYPASS;
    instr_type_d = 3'd0;
    illegal_d    = 1'b0;
    if (i_instr != 32'h0000_0000 && i_instr != 32'h0000_0013) begin
      case (opcode)
        OPC_LUI:   {alu_sel_d, instr_type_d} = {ALU_BYPASS, 3'd1};
        OPC_AUIPC: {alu_sel_d, instr_type_d} = {ALU_ADDER, 3'd0};
        OPC_JAL:   {alu_sel_d, instr_type_d} = {ALU_BRANCH, 3'd6};
        OPC_JALR:
          if (funct3 == 3'b000) {alu_sel_d, instr_type_d} = {ALU_BRANCH, 3'd7};
          else illegal_d = 1'b1;
        OPC_BRANCH:
          case (funct3)
            3'b000:  {alu_sel_d, instr_type_d} = {ALU_BRANCH, 3'd0};
            3'b001:  {alu_sel_d, instr_type_d} = {ALU_BRANCH, 3'd1};
            3'b100:  {alu_sel_d, instr_type_d} = {ALU_BRANCH, 3'd2};
            3'b110:  {alu_sel_d, instr_type_d} = {ALU_BRANCH, 3'd3};
            3'b101:  {alu_sel_d, instr_type_d} = {ALU_BRANCH, 3'd4};
            3'b111:  {alu_sel_d, instr_type_d} = {ALU_BRANCH, 3'd5};
            default: illegal_d = 1'b1;
          endcase
        OPC_LOAD:
          case (funct3)
            3'b000:  {alu_sel_d, instr_type_d} = {ALU_MEMORY, 3'd0};
            3'b100:  {alu_sel_d, instr_type_d} = {ALU_MEMORY, 3'd1};
            3'b001:  {alu_sel_d, instr_type_d} = {ALU_MEMORY, 3'd2};
            3'b101:  {alu_sel_d, instr_type_d} = {ALU_MEMORY, 3'd3};
            3'b010:  {alu_sel_d, instr_type_d} = {ALU_MEMORY, 3'd4};
            default: illegal_d = 1'b1;
          endcase
        OPC_STORE:
          case (funct3)
            3'b010:  {alu_sel_d, instr_type_d} = {ALU_MEMORY, 3'd5};
            3'b001:  {alu_sel_d, instr_type_d} = {ALU_MEMORY, 3'd6};
            3'b000:  {alu_sel_d, instr_type_d} = {ALU_MEMORY, 3'd7};
            default: illegal_d = 1'b1;
          endcase
        OPC_OPIMM:
          case (funct3)
            3'b000: {alu_sel_d, instr_type_d} = {ALU_ADDER, 3'd0};
            3'b010: {alu_sel_d, instr_type_d} = {ALU_ADDER, 3'd3};
            3'b011: {alu_sel_d, instr_type_d} = {ALU_ADDER, 3'd2};
            3'b100: {alu_sel_d, instr_type_d} = {ALU_LOGICAL, 3'd0};
            3'b110: {alu_sel_d, instr_type_d} = {ALU_LOGICAL, 3'd1};
            3'b111: {alu_sel_d, instr_type_d} = {ALU_LOGICAL, 3'd2};
            3'b001:
              if (funct7 == 7'b0000000) {alu_sel_d, instr_type_d} = {ALU_SHIFTER, 3'd0};
              else illegal_d = 1'b1;
            default:
              if (funct7 == 7'b0000000)      {alu_sel_d, instr_type_d} = {ALU_SHIFTER, 3'd1};
              else if (funct7 == 7'b0100000) {alu_sel_d, instr_type_d} = {ALU_SHIFTER, 3'd2};
              else illegal_d = 1'b1;
          endcase
        OPC_OP:
          if (funct7 == 7'b0000000) begin
            case (funct3)
              3'b000:  {alu_sel_d, instr_type_d} = {ALU_ADDER, 3'd0};
              3'b001:  {alu_sel_d, instr_type_d} = {ALU_SHIFTER, 3'd0};
              3'b010:  {alu_sel_d, instr_type_d} = {ALU_ADDER, 3'd3};
              3'b011:  {alu_sel_d, instr_type_d} = {ALU_ADDER, 3'd2};
              3'b100:  {alu_sel_d, instr_type_d} = {ALU_LOGICAL, 3'd0};
              3'b101:  {alu_sel_d, instr_type_d} = {ALU_SHIFTER, 3'd1};
              3'b110:  {alu_sel_d, instr_type_d} = {ALU_LOGICAL, 3'd1};
              default: {alu_sel_d, instr_type_d} = {ALU_LOGICAL, 3'd2};
            endcase
          end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
            {alu_sel_d, instr_type_d} = {ALU_ADDER, 3'd1};
          end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
            {alu_sel_d, instr_type_d} = {ALU_SHIFTER, 3'd2};
          end else begin
            illegal_d = 1'b1;
          end
        default: illegal_d = 1'b1;
      endcase
    end
  end

`ifdef DECODE_IMM_EN
  logic signed [31:0] imm_d;

  always_comb begin
    case (fmt_d)
      FMT_I:   imm_d = {{20{i_instr[31]}}, i_instr[31:20]};
      FMT_S:   imm_d = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      FMT_B:   imm_d = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                        i_instr[11:8], 1'b0};
      FMT_U:   imm_d = {i_instr[31:12], 12'h000};
      FMT_J:   imm_d = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                        i_instr[30:21], 1'b0};
      default: imm_d = '0;
    endcase
  end
`endif

  entry_t         entry_d;
  entry_t         mem_q [DEPTH];
  entry_t         head_e;
  logic [PW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]  count_q, count_d;
  logic           push, pop;

  always_comb begin
    entry_d.instr   = i_instr;
    entry_d.next_pc = i_next_pc;
    entry_d.fmt     = fmt_d;
    entry_d.alu     = alu_sel_d;
    entry_d.typ     = instr_type_d;
    entry_d.illegal = illegal_d;
    entry_d.tag     = i_tag;
`ifdef DECODE_IMM_EN
    entry_d.imm     = imm_d;
`endif
  end

  assign o_ready = (count_q != CW'(DEPTH));
  assign o_valid = (count_q != '0);
  assign push    = i_valid && o_ready && !i_flush;
  assign pop     = o_valid && i_ready && !i_flush;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (i_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + PW'(1);
      if (pop)  head_d = head_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; the empty-gating below hides stale contents.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[tail_q] <= entry_d;
  end

  assign head_e         = mem_q[head_q];
  assign o_instr        = o_valid ? head_e.instr   : '0;
  assign o_next_pc      = o_valid ? head_e.next_pc : '0;
  assign o_instr_format = o_valid ? head_e.fmt     : '0;
  assign o_alu_sel      = o_valid ? head_e.alu     : '0;
  assign o_instr_type   = o_valid ? head_e.typ     : '0;
  assign o_illegal      = o_valid ? head_e.illegal : 1'b0;
  assign o_tag          = o_valid ? head_e.tag     : '0;
  assign o_rd           = o_instr[11:7];
  assign o_rs1          = o_instr[19:15];
  assign o_rs2          = o_instr[24:20];
  assign o_count        = count_q;
`ifdef DECODE_IMM_EN
  assign o_imm          = o_valid ? head_e.imm : '0;
`else
  assign o_imm          = 32'h0;
`endif

endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: stimulus queues hand-computed records, a negedge monitor pops and compares.
module tb_decode_queue;

  localparam int DEPTH = 4;
  localparam logic [2:0] FI = 3'd0, FS = 3'd1, FB = 3'd2, FU = 3'd3, FJ = 3'd4, FR = 3'd5;
  localparam logic [2:0] ADD = 3'd0, LOG = 3'd1, SHF = 3'd2, BRA = 3'd3, MEM = 3'd4, BYP = 3'd5;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [2:0]  fmt;
    logic [2:0]  alu;
    logic [2:0]  typ;
    logic [31:0] imm;
    logic        ill;
    logic [3:0]  tag;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } rec_t;

  logic        i_clk = 1'b0;
  logic        i_rstn = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [31:0] i_instr = '0;
  logic [31:0] i_next_pc = '0;
  logic [3:0]  i_tag = '0;
  logic        i_flush = 1'b0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [4:0]  o_rs1, o_rs2, o_rd;
  logic [31:0] o_instr, o_next_pc, o_imm;
  logic [2:0]  o_instr_format, o_alu_sel, o_instr_type;
  logic        o_illegal;
  logic [3:0]  o_tag;
  logic [2:0]  o_count;

  int   vecs = 0;
  int   errs = 0;
  rec_t sb[$];
  logic [31:0] pc_gen = 32'h0000_1004;

  decode_queue #(.TAG_W(4), .DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_valid(i_valid), .o_ready(o_ready),
    .i_instr(i_instr), .i_next_pc(i_next_pc), .i_tag(i_tag), .i_flush(i_flush),
    .o_valid(o_valid), .i_ready(i_ready), .o_rs1(o_rs1), .o_rs2(o_rs2), .o_rd(o_rd),
    .o_instr(o_instr), .o_next_pc(o_next_pc), .o_instr_format(o_instr_format),
    .o_alu_sel(o_alu_sel), .o_instr_type(o_instr_type), .o_imm(o_imm),
    .o_illegal(o_illegal), .o_tag(o_tag), .o_count(o_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: a pop happens at the next rising edge whenever these hold at the falling edge.
  always @(negedge i_clk) begin
    if (i_rstn && !i_flush && o_valid && i_ready) begin
      rec_t act, exp;
      act = {o_instr, o_next_pc, o_instr_format, o_alu_sel, o_instr_type, o_imm,
             o_illegal, o_tag, o_rd, o_rs1, o_rs2};
      vecs++;
      if (sb.size() == 0) begin
        errs++;
        $display("FAIL unexpected_entry got=%h expected=none", act);
      end else begin
        exp = sb.pop_front();
        if (act !== exp) begin
          errs++;
          $display("FAIL entry_tag%0d got=%h expected=%h", exp.tag, act, exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic push(input logic [31:0] instr, input logic [3:0] tag, input logic [2:0] fmt,
                      input logic [2:0] alu, input logic [2:0] typ, input logic [31:0] imm,
                      input logic ill, input logic [4:0] rd);
    rec_t r;
    bit   acc;
    int   n;
    r.instr = instr; r.pc = pc_gen; r.fmt = fmt; r.alu = alu; r.typ = typ;
`ifdef DECODE_IMM_EN
    r.imm = imm;
`else
    r.imm = 32'h0;
`endif
    r.ill = ill; r.tag = tag; r.rd = rd; r.rs1 = instr[19:15]; r.rs2 = instr[24:20];
    i_valid = 1'b1; i_instr = instr; i_next_pc = pc_gen; i_tag = tag;
    acc = 1'b0; n = 0;
    while (!acc && n < 50) begin
      acc = o_ready;
      tick();
      n++;
    end
    i_valid = 1'b0;
    pc_gen = pc_gen + 32'd4;
    if (acc) sb.push_back(r);
    else begin
      vecs++; errs++;
      $display("FAIL push_timeout got=ready_low expected=accept");
    end
  endtask

  task automatic check_empty(input string tagname);
    check({tagname, "_valid"}, {31'h0, o_valid}, 32'h0);
    check({tagname, "_ready"}, {31'h0, o_ready}, 32'h1);
    check({tagname, "_count"}, {29'h0, o_count}, 32'h0);
    check({tagname, "_instr"}, o_instr, 32'h0);
    check({tagname, "_tag"}, {28'h0, o_tag}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) tick();
    check_empty("reset");
    check("reset_imm", o_imm, 32'h0);
    i_rstn = 1'b1;
    tick();

    // Single-entry latency with dispatch ready.
    i_ready = 1'b1;
    push(32'h0050_0093, 4'd1, FI, ADD, 3'd0, 32'h0000_0005, 1'b0, 5'd1);
    check("lat_valid", {31'h0, o_valid}, 32'h1);
    check("lat_count", {29'h0, o_count}, 32'h1);
    tick();
    check("lat_drained", {29'h0, o_count}, 32'h0);

    push(32'hFE20_8EE3, 4'd2, FB, BRA, 3'd0, 32'hFFFF_FFFC, 1'b0, 5'd29);
    push(32'hFFFF_FFFF, 4'd3, FR, BYP, 3'd0, 32'h0,         1'b1, 5'd31);
    push(32'h0000_0013, 4'd4, FI, BYP, 3'd0, 32'h0,         1'b0, 5'd0);
    push(32'h0000_0000, 4'd5, FR, BYP, 3'd0, 32'h0,         1'b0, 5'd0);
    push(32'h4020_81B3, 4'd6, FR, ADD, 3'd1, 32'h0,         1'b0, 5'd3);
    push(32'h0020_A423, 4'd7, FS, MEM, 3'd5, 32'h0000_0008, 1'b0, 5'd8);
    push(32'h4032_D293, 4'd8, FI, SHF, 3'd2, 32'h0000_0403, 1'b0, 5'd5);
    push(32'h6032_D293, 4'd9, FI, BYP, 3'd0, 32'h0000_0603, 1'b1, 5'd5);
    push(32'hFF9F_F0EF, 4'd10, FJ, BRA, 3'd6, 32'hFFFF_FFF8, 1'b0, 5'd1);
    check("stream_count", {29'h0, o_count}, 32'h1);
    tick();
    check("stream_drained", {29'h0, o_count}, 32'h0);

    // Fill to DEPTH with dispatch stalled.
    i_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++)
      push((32'(k + 1) << 20) | 32'h0000_0093, 4'(k), FI, ADD, 3'd0, 32'(k + 1), 1'b0, 5'd1);
    check("full_count", {29'h0, o_count}, DEPTH);
    check("full_ready", {31'h0, o_ready}, 32'h0);
    i_valid = 1'b1; i_instr = 32'h0630_0093; i_tag = 4'hF;
    tick();
    i_valid = 1'b0;
    check("full_reject_count", {29'h0, o_count}, DEPTH);
    check("full_head_tag", {28'h0, o_tag}, 32'h0);
    i_ready = 1'b1;
    tick();
    check("unfull_ready", {31'h0, o_ready}, 32'h1);
    check("unfull_count", {29'h0, o_count}, DEPTH - 1);
    repeat (DEPTH) tick();
    check("drain_count", {29'h0, o_count}, 32'h0);

    // Flush with a same-cycle push.
    i_ready = 1'b0;
    push(32'h0010_0113, 4'd5, FI, ADD, 3'd0, 32'h1, 1'b0, 5'd2);
    push(32'h0020_0113, 4'd6, FI, ADD, 3'd0, 32'h2, 1'b0, 5'd2);
    push(32'h0030_0113, 4'd7, FI, ADD, 3'd0, 32'h3, 1'b0, 5'd2);
    check("preflush_count", {29'h0, o_count}, 32'h3);
    i_flush = 1'b1; i_valid = 1'b1; i_instr = 32'h0040_0113; i_tag = 4'd8;
    tick();
    i_flush = 1'b0; i_valid = 1'b0;
    sb.delete();
    check_empty("flush");
    i_ready = 1'b1;
    tick();
    check("postflush_count", {29'h0, o_count}, 32'h0);

    // Reset in the middle of operation.
    i_ready = 1'b0;
    push(32'h0050_0093, 4'd1, FI, ADD, 3'd0, 32'h5, 1'b0, 5'd1);
    push(32'h0060_0093, 4'd2, FI, ADD, 3'd0, 32'h6, 1'b0, 5'd1);
    i_rstn = 1'b0;
    tick();
    i_rstn = 1'b1;
    sb.delete();
    check_empty("midreset");
    i_ready = 1'b1;
    push(32'h1234_50B7, 4'd9, FU, BYP, 3'd1, 32'h1234_5000, 1'b0, 5'd1);
    check("lui_valid", {31'h0, o_valid}, 32'h1);
    repeat (3) tick();

    check("scoreboard_left", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
